// File: rtl/key_msg_tx.sv
// Turns single-cycle key-press pulses into "K<n>\r\n" messages for the UART
// transmitter. Pending presses are queued by key, served lowest key first, and overruns are counted.
module key_msg_tx #(
  parameter int GUARD_CYC = 2,
  parameter bit CRLF_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_evt,
  input  logic       tx_busy,
  output logic [7:0] din,
  output logic       wr_en,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam logic [1:0] LAST_IDX = CRLF_EN ? 2'd3 : 2'd1;

  typedef enum logic [1:0] {IDLE, SEND, GUARD, WAIT} state_t;

  state_t     state_reg, state_next;
  logic [3:0] pend_reg, pend_next;
  logic [1:0] idx_reg, idx_next;
  logic [1:0] bidx_reg, bidx_next;
  logic [3:0] guard_reg, guard_next;
  logic [7:0] din_reg, din_next;
  logic [7:0] drop_reg, drop_next;
  logic [3:0] clr_mask, drop_vec;
  logic [2:0] drop_sum;
  logic [8:0] drop_tot;
  logic [1:0] sel;
  logic       load;

  function automatic logic [7:0] byte_at(input logic [1:0] b, input logic [1:0] i);
    case (b)
      2'd0:    byte_at = 8'h4B;
      2'd1:    byte_at = 8'h31 + {6'd0, i};
      2'd2:    byte_at = 8'h0D;
      default: byte_at = 8'h0A;
    endcase
  endfunction

  // Fixed priority: K1 wins over K2 over K3 over K4.
  always_comb begin
    if (pend_reg[0])      sel = 2'd0;
    else if (pend_reg[1]) sel = 2'd1;
    else if (pend_reg[2]) sel = 2'd2;
    else                  sel = 2'd3;
  end

  // A bit cleared by LOAD this cycle neither latches a new press nor counts as a drop.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pend
      assign clr_mask[gi]  = load && (sel == 2'(gi));
      assign drop_vec[gi]  = key_evt[gi] & pend_reg[gi] & ~clr_mask[gi];
      assign pend_next[gi] = (pend_reg[gi] | key_evt[gi]) & ~clr_mask[gi];
    end
  endgenerate

  always_comb begin
    drop_sum  = {2'd0, drop_vec[0]} + {2'd0, drop_vec[1]} + {2'd0, drop_vec[2]} + {2'd0, drop_vec[3]};
    drop_tot  = {1'b0, drop_reg} + {6'd0, drop_sum};
    drop_next = (drop_tot > 9'd255) ? 8'd255 : drop_tot[7:0];
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    bidx_next  = bidx_reg;
    guard_next = guard_reg;
    din_next   = din_reg;
    wr_en      = 1'b0;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pend_reg != 4'd0) begin
          load       = 1'b1;
          idx_next   = sel;
          bidx_next  = 2'd0;
          din_next   = byte_at(2'd0, sel);
          state_next = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          wr_en      = 1'b1;
          guard_next = 4'(GUARD_CYC);
          state_next = GUARD;
        end
      end
      // tx_busy may not have risen yet right after the strobe, so it is ignored here.
      GUARD: begin
        guard_next = guard_reg - 4'd1;
        if (guard_reg <= 4'd1) state_next = WAIT;
      end
      WAIT: begin
        if (!tx_busy) begin
          if (bidx_reg == LAST_IDX) begin
            state_next = IDLE;
          end else begin
            bidx_next  = bidx_reg + 2'd1;
            din_next   = byte_at(bidx_reg + 2'd1, idx_reg);
            state_next = SEND;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      pend_reg  <= 4'd0;
      idx_reg   <= 2'd0;
      bidx_reg  <= 2'd0;
      guard_reg <= 4'd0;
      din_reg   <= 8'h00;
      drop_reg  <= 8'd0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      idx_reg   <= idx_next;
      bidx_reg  <= bidx_next;
      guard_reg <= guard_next;
      din_reg   <= din_next;
      drop_reg  <= drop_next;
    end
  end

  assign din      = din_reg;
  assign busy     = (state_reg != IDLE);
  assign drop_cnt = drop_reg;

endmodule

// File: tb/tb_key_msg_tx.sv
// Drives two key_msg_tx instances (default CRLF build, and 2-byte GUARD_CYC=1 build)
// against a timestamp-based reference model of messages, drops and strobe timing.
module tb_key_msg_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_a = 4'd0, key_b = 4'd0;
  logic       txb_a = 1'b0;
  logic       txb_b = 1'b0;
  logic [7:0] din_a, din_b, drop_a, drop_b;
  logic       wr_a, wr_b, busy_a, busy_b;

  key_msg_tx #(.GUARD_CYC(2), .CRLF_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .key_evt(key_a), .tx_busy(txb_a),
    .din(din_a), .wr_en(wr_a), .busy(busy_a), .drop_cnt(drop_a)
  );

  key_msg_tx #(.GUARD_CYC(1), .CRLF_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .key_evt(key_b), .tx_busy(txb_b),
    .din(din_b), .wr_en(wr_b), .busy(busy_b), .drop_cnt(drop_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int busy_cnt = 0;
  bit stick = 1'b0, stick_arm = 1'b0;

  // Reference model state, one slot per instance.
  int         g_of[2]    = '{2, 1};
  bit         crlf_of[2] = '{1'b1, 1'b0};
  logic [3:0] m_pend[2];
  int         m_drop[2];
  bit         m_busy[2], got_gap[2];
  int         gap_cyc[2], wait_from[2], qhead[2], qlen[2];
  logic [7:0] qb[2][4];
  logic [7:0] log_b[2][64];
  int         log_c[2][64];
  int         log_n[2];

  task automatic check_val(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, obs, obs, exp, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 4'd0; m_drop[k] = 0; m_busy[k] = 1'b0; got_gap[k] = 1'b0;
      gap_cyc[k] = 0; wait_from[k] = 0; qhead[k] = 0; qlen[k] = 0; log_n[k] = 0;
    end
  endtask

  task automatic step(input int k, input logic [3:0] key, input logic txb, input logic wr,
                      input logic [7:0] din, input logic bsy, input logic [7:0] drp);
    bit         exp_wr;
    logic [3:0] clr;
    int         sel;
    string      sfx;
    sfx = (k == 0) ? "_a" : "_b";
    exp_wr = m_busy[k] && got_gap[k] && (cyc > gap_cyc[k]) && !txb && (qhead[k] < qlen[k]);
    check_val({"wr_en", sfx}, int'(wr), int'(exp_wr));
    check_val({"busy", sfx}, int'(bsy), int'(m_busy[k]));
    check_val({"drop_cnt", sfx}, int'(drp), m_drop[k]);
    if (exp_wr) begin
      check_val({"din", sfx}, int'(din), int'(qb[k][qhead[k]]));
      $display("[TB] dut%s wr din=0x%02h cycle=%0d", sfx, din, cyc);
      if (log_n[k] < 64) begin
        log_b[k][log_n[k]] = din;
        log_c[k][log_n[k]] = cyc;
        log_n[k]++;
      end
      qhead[k]++;
      got_gap[k]   = 1'b0;
      wait_from[k] = cyc + g_of[k] + 1;
    end
    clr = 4'd0;
    if (m_busy[k]) begin
      if (!got_gap[k] && !exp_wr && cyc >= wait_from[k] && !txb) begin
        if (qhead[k] == qlen[k]) m_busy[k] = 1'b0;
        else begin got_gap[k] = 1'b1; gap_cyc[k] = cyc; end
      end
    end else if (m_pend[k] != 4'd0) begin
      sel = 3;
      for (int b = 3; b >= 0; b--) if (m_pend[k][b]) sel = b;
      clr[sel] = 1'b1;
      qb[k][0] = 8'h4B;
      qb[k][1] = 8'h31 + 8'(sel);
      qb[k][2] = 8'h0D;
      qb[k][3] = 8'h0A;
      qlen[k]  = crlf_of[k] ? 4 : 2;
      qhead[k] = 0;
      m_busy[k] = 1'b1; got_gap[k] = 1'b1; gap_cyc[k] = cyc;
    end
    for (int b = 0; b < 4; b++)
      if (key[b] && m_pend[k][b] && !clr[b] && m_drop[k] < 255) m_drop[k]++;
    m_pend[k] = (m_pend[k] | key) & ~clr;
  endtask

  task automatic tick(input logic [3:0] ka, input logic [3:0] kb);
    @(posedge clk); #1;
    cyc++;
    key_a = ka;
    key_b = kb;
    txb_a = stick || (busy_cnt > 0);
    @(negedge clk);
    step(0, key_a, txb_a, wr_a, din_a, busy_a, drop_a);
    step(1, key_b, txb_b, wr_b, din_b, busy_b, drop_b);
    if (wr_a && stick_arm) stick = 1'b1;
    if (wr_a) busy_cnt = 10;
    else if (busy_cnt > 0) busy_cnt--;
  endtask

  // Called right after a tick's sampling point, so the asynchronous reset lands mid-cycle.
  task automatic do_reset();
    #2;
    rst = 1'b1; key_a = 4'd0; key_b = 4'd0;
    stick = 1'b0; stick_arm = 1'b0; busy_cnt = 0; txb_a = 1'b0;
    #1;
    check_val("rst_din_a", int'(din_a), 0);
    check_val("rst_wr_a", int'(wr_a), 0);
    check_val("rst_busy_a", int'(busy_a), 0);
    check_val("rst_drop_a", int'(drop_a), 0);
    check_val("rst_din_b", int'(din_b), 0);
    check_val("rst_busy_b", int'(busy_b), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
  endtask

  task automatic drain();
    int budget;
    budget = 3000;
    while ((m_busy[0] || m_busy[1] || m_pend[0] != 4'd0 || m_pend[1] != 4'd0) && budget > 0) begin
      tick(4'd0, 4'd0);
      budget--;
    end
    check_val("drain_timeout", int'(budget == 0), 0);
    repeat (3) tick(4'd0, 4'd0);
  endtask

  task automatic check_msg(input int k, input int base, input logic [7:0] n);
    string sfx;
    sfx = (k == 0) ? "_a" : "_b";
    check_val({"msg_k", sfx}, int'(log_b[k][base]), 8'h4B);
    check_val({"msg_n", sfx}, int'(log_b[k][base + 1]), int'(8'h30 + n));
    if (crlf_of[k]) begin
      check_val({"msg_cr", sfx}, int'(log_b[k][base + 2]), 8'h0D);
      check_val({"msg_lf", sfx}, int'(log_b[k][base + 3]), 8'h0A);
    end
  endtask

  int evt_cyc;

  initial begin
    model_clear();
    do_reset();

    // Single K2 press with a 10-cycle transmitter busy after each strobe.
    tick(4'b0010, 4'd0);
    evt_cyc = cyc;
    drain();
    check_val("k2_strobes", log_n[0], 4);
    check_msg(0, 0, 8'd2);
    check_val("k2_latency", log_c[0][0] - evt_cyc, 2);
    check_val("k2_busy_end", int'(busy_a), 0);
    check_val("k2_drop", int'(drop_a), 0);

    // K1 and K4 together: K1 first, then K4, no interleave.
    log_n[0] = 0;
    tick(4'b1001, 4'd0);
    drain();
    check_val("k14_strobes", log_n[0], 8);
    check_msg(0, 0, 8'd1);
    check_msg(0, 4, 8'd4);

    // Three K3 presses during K2: one K3 message, two drops.
    do_reset();
    tick(4'b0010, 4'd0);
    repeat (5) tick(4'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin tick(4'b0100, 4'd0); repeat (2) tick(4'd0, 4'd0); end
    drain();
    check_val("k3_strobes", log_n[0], 8);
    check_msg(0, 0, 8'd2);
    check_msg(0, 4, 8'd3);
    check_val("k3_drop", int'(drop_a), 2);

    // K2 re-pressed after its own load: second K2 message, no drop.
    do_reset();
    tick(4'b0010, 4'd0);
    repeat (5) tick(4'd0, 4'd0);
    tick(4'b0010, 4'd0);
    drain();
    check_val("k22_strobes", log_n[0], 8);
    check_msg(0, 0, 8'd2);
    check_msg(0, 4, 8'd2);
    check_val("k22_drop", int'(drop_a), 0);

    // Transmitter stuck busy after the first byte, then reset mid-message.
    do_reset();
    stick_arm = 1'b1;
    tick(4'b0001, 4'd0);
    repeat (60) tick(4'd0, 4'd0);
    check_val("stall_strobes", log_n[0], 1);
    check_val("stall_busy", int'(busy_a), 1);
    do_reset();
    tick(4'b0100, 4'd0);
    drain();
    check_val("post_rst_strobes", log_n[0], 4);
    check_msg(0, 0, 8'd3);

    // 2-byte build, GUARD_CYC=1, tx_busy tied low.
    do_reset();
    tick(4'd0, 4'b1000);
    drain();
    check_val("b_strobes", log_n[1], 2);
    check_msg(1, 0, 8'd4);
    check_val("b_spacing", log_c[1][1] - log_c[1][0], 3);
    check_val("b_busy_end", int'(busy_b), 0);

    // K1 keeps winning while K4 stays pending and overruns every cycle.
    for (int i = 0; i < 300; i++) tick(4'd0, 4'b1001);
    check_val("b_drop_sat", int'(drop_b), 255);
    drain();
    check_val("b_drop_hold", int'(drop_b), 255);

    // Randomized key traffic on both instances.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [3:0] ra, rb;
      ra = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
      rb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      tick(ra, rb);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_msg_tx.md
Name: key_msg_tx

Overview:
- Sits directly upstream of the UART transmitter and drives its din/wr_en/tx_busy port group.
- Converts single-cycle key-press events from the key stage into ASCII report messages: "K1\r\n" through "K4\r\n".
- Latches events that arrive while a message is in flight, arbitrates them by fixed priority, and counts events it has to drop.
- Gives the factory test a serial log of every key press.

Parameters:
- GUARD_CYC, 2: cycles after each wr_en pulse during which tx_busy is ignored. Covers the transmitter's busy-assert latency. Legal range 1..15.
- CRLF_EN, 1: 1 sends 4-byte messages "K<n>\r\n"; 0 sends 2-byte messages "K<n>".

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst, input, 1: asynchronous, active-high reset.
- key_evt, input, 4: one-cycle press pulses; bit i = key K(i+1); synchronous to clk.
- tx_busy, input, 1: UART transmitter busy; high while a byte is being shifted out.
- din, output, 8: byte to the transmitter; valid when wr_en=1, held until the next wr_en.
- wr_en, output, 1: one-cycle write strobe to the transmitter.
- busy, output, 1: high from message start until the last byte's tx_busy falls.
- drop_cnt, output, 8: saturating count of dropped events.

Behaviour:
- Reset (async, rst=1):
  - pend=0, state=IDLE, byte index=0.
  - din=8'h00, wr_en=0, busy=0, drop_cnt=0.
  - Outputs are forced immediately, including mid-message. No partial message resumes after reset.
- Pending register pend[3:0]:
  - Each cycle: pend |= key_evt, except the bit being cleared by LOAD that same cycle.
  - Drop rule: if key_evt[i]=1 while pend[i] is already 1 and not being cleared, drop_cnt increments by one.
  - Several bits dropping in one cycle add their total count.
  - drop_cnt saturates at 255.
  - A pulse on the key currently being transmitted, arriving after its pend bit was cleared, re-sets pend. It is not a drop.
- FSM states: IDLE, SEND, GUARD, WAIT.
  - IDLE:
    - If pend≠0, select the lowest set bit i, clear pend[i], latch idx=i and byte index=0, set busy=1, and go to SEND next cycle.
    - If pend=0, stay in IDLE with busy=0.
  - SEND:
    - When tx_busy=0: assert wr_en for exactly one cycle with din = current byte, load the guard counter with GUARD_CYC, and go to GUARD.
    - When tx_busy=1: wait in SEND with wr_en=0.
  - GUARD: decrement the counter each cycle; go to WAIT when it reaches 0. tx_busy is ignored in this state.
  - WAIT:
    - When tx_busy=0 and this is not the last byte: increment byte index and go to SEND.
    - When tx_busy=0 and this is the last byte: go to IDLE and clear busy the same cycle.
- Byte sequence:
  - Byte 0: 8'h4B ('K').
  - Byte 1: 8'h31 + idx.
  - If CRLF_EN=1, byte 2: 8'h0D; byte 3: 8'h0A.
  - Last byte index = 3 if CRLF_EN=1, else 1.
- Latency:
  - Event pulse at cycle n, with FSM in IDLE and tx_busy=0: pend set at n+1, LOAD at n+1, first wr_en at n+2.
  - Minimum spacing between wr_en pulses is GUARD_CYC+2 cycles, even if tx_busy never rises.
- Simultaneous events: all bits are latched in the same cycle. Messages are then sent in ascending key order (K1 first), one full message each. Every bit is latched, so none of them count as drops.
- Messages are never interleaved or truncated. wr_en is never asserted while in GUARD or WAIT.
- Unsynchronised or unknown key_evt is out of scope; the upstream stage guarantees single-cycle synchronous pulses.

Test Plan:
- Reset then key_evt=4'b0010 for 1 cycle; model tx_busy high for 10 cycles after each wr_en (from the next cycle) -> wr_en at n+2 with din=0x4B, then 0x32, 0x0D, 0x0A. Exactly 4 strobes. busy clears when the last tx_busy falls. drop_cnt=0.
- key_evt=4'b1001 in one cycle -> "K1\r\n" (4B 31 0D 0A) followed by "K4\r\n" (4B 34 0D 0A). 8 strobes total, no interleave.
- During K2's message, pulse key_evt[2] three times -> one "K3\r\n" sent after K2. drop_cnt=2.
- During K2's message (after its LOAD), pulse key_evt[1] once -> a second "K2\r\n" follows. drop_cnt=0.
- Hold tx_busy=1 permanently after the first byte -> wr_en pulses exactly once, FSM stalls in WAIT, busy=1. Assert rst mid-message -> wr_en=0, busy=0, din=0x00 immediately. After release, a new event sends a full 4-byte message.
- CRLF_EN=0, GUARD_CYC=1, tx_busy tied 0 -> key_evt[3] yields wr_en with 0x4B, then 0x34 exactly 3 cycles later. busy deasserts after byte 1. Then 300 repeated pulses on a held pend bit -> drop_cnt saturates at 255.
